// File: rtl/button_pio_in_pkg.sv
// button_pio_in_pkg: register map and edge-mode encodings shared by the button PIO
package button_pio_in_pkg;
  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RSVD     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;
  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_mode_e;
endpackage

// File: rtl/pio_debounce_bit.sv
// pio_debounce_bit: 2-FF synchroniser plus hold-time debounce for one input bit
module pio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_bit,
  output logic stable
);
  localparam int CW = DEBOUNCE_CYCLES > 2 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  logic s1_q, s2_q, stable_q, stable_d, diff, done;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    diff     = s2_q != stable_q;
    done     = diff && cnt_q == CMAX;
    cnt_d    = diff && !done ? cnt_q + 1'b1 : '0;
    stable_d = done ? s2_q : stable_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= IDLE_LEVEL;
      s2_q     <= IDLE_LEVEL;
      stable_q <= IDLE_LEVEL;
      cnt_q    <= '0;
    end else begin
      s1_q     <= in_bit;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end
  assign stable = stable_q;
endmodule

// File: rtl/button_pio_in.sv
// button_pio_in: Avalon-MM input PIO with debounced inputs, sticky edge capture and masked irq
module button_pio_in
  import button_pio_in_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 1,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam logic [WIDTH-1:0] IDLE = {WIDTH{IDLE_LEVEL}};
  logic [WIDTH-1:0] stable, rise, fall, edges, clr;
  logic [WIDTH-1:0] prev_q, prev_d, mask_q, mask_d, cap_q, cap_d;
  logic [31:0] rdata_q, rdata_d;
  logic irq_q, irq_d, wr;
  logic unused_wdata;
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (IDLE_LEVEL)
    ) u_db (
      .clk   (clk),
      .rst   (reset),
      .in_bit(in_port[i]),
      .stable(stable[i])
    );
  end
  assign unused_wdata = &{1'b0, writedata};
  always_comb begin
    wr      = chipselect & ~write_n;
    rise    = stable & ~prev_q;
    fall    = ~stable & prev_q;
    edges   = EDGE_MODE == int'(EDGE_RISE) ? rise :
              EDGE_MODE == int'(EDGE_FALL) ? fall : rise | fall;
    clr     = wr && address == ADDR_EDGE_CAP ? writedata[WIDTH-1:0] : '0;
    prev_d  = stable;
    mask_d  = wr && address == ADDR_IRQ_MASK ? writedata[WIDTH-1:0] : mask_q;
    cap_d   = (cap_q & ~clr) | edges;
    rdata_d = address == ADDR_DATA     ? 32'(stable) :
              address == ADDR_IRQ_MASK ? 32'(mask_q) :
              address == ADDR_EDGE_CAP ? 32'(cap_q)  : '0;
    irq_d   = |(cap_q & mask_q);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= IDLE;
      mask_q  <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end
  assign readdata = rdata_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_button_pio_in.sv
// tb_button_pio_in: directed stimulus checked against a window-based behavioural model every cycle
module tb_button_pio_in;
  localparam int D = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] address = 2'd0;
  logic chipselect = 1'b0, write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0] in_port = 4'hF;
  logic [31:0] readdata;
  logic irq;
  int checks = 0, errors = 0;

  button_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_MODE(1), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  // Model: a bit is accepted once the synchronised input has disagreed with it for D edges in a row
  logic [3:0] raw_q[$];
  logic [3:0] m_stable, m_prev, m_mask, m_cap, m_nst, m_edge, m_clr, m_tmp;
  logic [31:0] m_rd;
  logic m_irq, m_diff, m_wr;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_stable = 4'hF; m_prev = 4'hF; m_mask = '0; m_cap = '0; m_rd = '0; m_irq = 1'b0;
      raw_q.delete();
      for (int j = 0; j < D + 2; j++) raw_q.push_back(4'hF);
    end else begin
      raw_q.push_back(in_port);
      if (raw_q.size() > D + 2) void'(raw_q.pop_front());
      m_nst = m_stable;
      for (int b = 0; b < 4; b++) begin
        m_diff = 1'b1;
        for (int j = 0; j < D; j++) begin
          m_tmp = raw_q[raw_q.size() - 3 - j];
          if (m_tmp[b] == m_stable[b]) m_diff = 1'b0;
        end
        if (m_diff) m_nst[b] = ~m_stable[b];
      end
      m_edge = ~m_stable & m_prev;
      m_wr = chipselect && !write_n;
      m_clr = (m_wr && address == 2'd3) ? writedata[3:0] : 4'h0;
      m_rd = address == 2'd0 ? {28'd0, m_stable} : address == 2'd2 ? {28'd0, m_mask} :
             address == 2'd3 ? {28'd0, m_cap} : 32'd0;
      m_irq = |(m_cap & m_mask);
      m_cap = (m_cap & ~m_clr) | m_edge;
      if (m_wr && address == 2'd2) m_mask = writedata[3:0];
      m_prev = m_stable;
      m_stable = m_nst;
    end
  end

  always @(negedge clk) begin
    chk("cyc_readdata", readdata, m_rd);
    chk("cyc_irq", {31'd0, irq}, {31'd0, m_irq});
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string n);
    address = a;
    @(negedge clk);
    chk(n, readdata, exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    reset = 1'b0;
    rd(2'd0, 32'hF, "data_idle");
    chk("irq_idle", {31'd0, irq}, 32'h0);
    rd(2'd3, 32'h0, "cap_idle");
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 32'h0, "rsvd_read");
    wr(2'd0, 32'h0);
    rd(2'd0, 32'hF, "data_ro");
    in_port = 4'hE;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 6) chk("data_before", readdata, 32'hF);
      if (i == 7) chk("data_after", readdata, 32'hE);
    end
    rd(2'd3, 32'h1, "cap_fall0");
    chk("model_cap0", {28'd0, m_cap}, 32'h1);
    chk("irq_masked", {31'd0, irq}, 32'h0);
    wr(2'd2, 32'h1);
    chk("irq_lag", {31'd0, irq}, 32'h0);
    @(negedge clk);
    chk("irq_on", {31'd0, irq}, 32'h1);
    wr(2'd3, 32'h1);
    @(negedge clk);
    chk("irq_off", {31'd0, irq}, 32'h0);
    rd(2'd3, 32'h0, "cap_clr");
    in_port = 4'hD;
    repeat (3) @(negedge clk);
    in_port = 4'hF;
    repeat (8) @(negedge clk);
    rd(2'd0, 32'hF, "glitch_data");
    rd(2'd3, 32'h0, "glitch_cap");
    for (int i = 0; i < 10; i++) begin
      in_port[1] = ~in_port[1];
      repeat (2) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    rd(2'd0, 32'hF, "bounce_data");
    rd(2'd3, 32'h0, "bounce_cap");
    chk("model_bounce", {28'd0, m_stable}, 32'hF);
    in_port = 4'hB;
    repeat (6) @(negedge clk);
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h4, "cap_set_wins");
    chk("model_set_wins", {28'd0, m_cap}, 32'h4);
    wr(2'd2, 32'h4);
    @(negedge clk);
    chk("irq_b2", {31'd0, irq}, 32'h1);
    in_port = 4'h3;
    repeat (4) @(negedge clk);
    in_port = 4'hF;
    #2 reset = 1'b1;
    #1 chk("midrst_readdata", readdata, 32'h0);
    chk("midrst_irq", {31'd0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    rd(2'd0, 32'hF, "post_rst_data");
    rd(2'd3, 32'h0, "post_rst_cap");
    rd(2'd2, 32'h0, "post_rst_mask");
    chk("post_rst_irq", {31'd0, irq}, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
